// File: rtl/lock_sequencer_if.sv
// Signal bundle between the lock front-end controller and its environment:
// raw buttons and lock status in, gated press pulses and lock control out.
interface lock_sequencer_if #(
    parameter int MAX_FAILS = 32'd3
);
    logic                           b0_raw_in;
    logic                           b1_raw_in;
    logic                           lock_open_in;
    logic                           b0_pulse_out;
    logic                           b1_pulse_out;
    logic                           lock_reset_out;
    logic                           unlocked_out;
    logic                           lockout_out;
    logic [$clog2(MAX_FAILS+1)-1:0] fail_count_out;

    modport master (
        output b0_raw_in, b1_raw_in, lock_open_in,
        input  b0_pulse_out, b1_pulse_out, lock_reset_out,
        input  unlocked_out, lockout_out, fail_count_out
    );

    modport slave (
        input  b0_raw_in, b1_raw_in, lock_open_in,
        output b0_pulse_out, b1_pulse_out, lock_reset_out,
        output unlocked_out, lockout_out, fail_count_out
    );
endinterface

// File: rtl/lock_sequencer.sv
// Front-end controller for a combination lock: debounces two buttons, gates presses into
// fixed-length attempts, tracks failures, and drives lockout and timed auto-relock.
module lock_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 32'd500000,
    parameter int unsigned CODE_LEN        = 32'd5,
    parameter int unsigned MAX_FAILS       = 32'd3,
    parameter int unsigned UNLOCK_CYCLES   = 32'd50000000,
    parameter int unsigned LOCKOUT_CYCLES  = 32'd250000000,
    parameter int unsigned ENTRY_TIMEOUT   = 32'd100000000
) (
    input  logic             clk,
    input  logic             reset_n_in,
    lock_sequencer_if.slave  bus
);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 32'd1);
    localparam int PRS_W  = $clog2(CODE_LEN + 32'd1);
    localparam int FAIL_W = $clog2(MAX_FAILS + 32'd1);
    localparam int UNL_W  = $clog2(UNLOCK_CYCLES + 32'd1);
    localparam int LKO_W  = $clog2(LOCKOUT_CYCLES + 32'd1);
    localparam int TO_W   = $clog2(ENTRY_TIMEOUT + 32'd1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [PRS_W-1:0]  CODE_LAST = PRS_W'(CODE_LEN);
    localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAILS);
    localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAILS - 32'd1);
    localparam logic [UNL_W-1:0]  UNL_LAST  = UNL_W'(UNLOCK_CYCLES - 32'd1);
    localparam logic [LKO_W-1:0]  LKO_LAST  = LKO_W'(LOCKOUT_CYCLES - 32'd1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ENTRY_TIMEOUT - 32'd1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ENTRY    = 3'd1,
        ST_CHECK    = 3'd2,
        ST_UNLOCKED = 3'd3,
        ST_RELOCK   = 3'd4,
        ST_LOCKOUT  = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             meta_q, meta_d;
    logic [1:0]             sync_q, sync_d;
    logic [1:0]             deb_q, deb_d;
    logic [1:0][DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [PRS_W-1:0]       press_cnt_q, press_cnt_d;
    logic [TO_W-1:0]        timeout_q, timeout_d;
    logic [UNL_W-1:0]       unlock_cnt_q, unlock_cnt_d;
    logic [LKO_W-1:0]       lockout_cnt_q, lockout_cnt_d;
    logic [FAIL_W-1:0]      fail_cnt_q, fail_cnt_d;
    logic                   b0_pulse_q, b0_pulse_d;
    logic                   b1_pulse_q, b1_pulse_d;
    logic                   lock_reset_q, lock_reset_d;
    logic                   unlocked_q, unlocked_d;
    logic                   lockout_q, lockout_d;
    logic [1:0]             press_s;
    logic                   both_s;
    logic                   fail_s;

    // Synchronise and debounce; a press fires on the same edge the debounced level rises.
    always_comb begin
        meta_d = {bus.b1_raw_in, bus.b0_raw_in};
        sync_d = meta_q;
        for (int i = 0; i < 2; i++) begin
            if (sync_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i]     = sync_q[i];
                    deb_cnt_d[i] = {DEB_W{1'b0}};
                    press_s[i]   = sync_q[i];
                end else begin
                    deb_d[i]     = deb_q[i];
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
                    press_s[i]   = 1'b0;
                end
            end else begin
                deb_d[i]     = deb_q[i];
                deb_cnt_d[i] = {DEB_W{1'b0}};
                press_s[i]   = 1'b0;
            end
        end
        both_s = press_s[0] & press_s[1];
    end

    // Attempt sequencing; failures from any state are resolved after the case.
    always_comb begin
        state_d       = state_q;
        press_cnt_d   = press_cnt_q;
        timeout_d     = timeout_q;
        unlock_cnt_d  = unlock_cnt_q;
        lockout_cnt_d = lockout_cnt_q;
        fail_cnt_d    = fail_cnt_q;
        b0_pulse_d    = 1'b0;
        b1_pulse_d    = 1'b0;
        fail_s        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (both_s) begin
                    fail_s = 1'b1;
                end else if (|press_s) begin
                    b0_pulse_d  = press_s[0];
                    b1_pulse_d  = press_s[1];
                    press_cnt_d = PRS_W'(1);
                    timeout_d   = {TO_W{1'b0}};
                    state_d     = ST_ENTRY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ENTRY: begin
                // The lock needs one cycle to absorb the final pulse before CHECK samples it.
                if (press_cnt_q == CODE_LAST) begin
                    state_d = ST_CHECK;
                end else if (both_s) begin
                    fail_s = 1'b1;
                end else if (|press_s) begin
                    b0_pulse_d  = press_s[0];
                    b1_pulse_d  = press_s[1];
                    press_cnt_d = press_cnt_q + PRS_W'(1);
                    timeout_d   = {TO_W{1'b0}};
                end else if (timeout_q == TO_LAST) begin
                    fail_s = 1'b1;
                end else begin
                    timeout_d = timeout_q + TO_W'(1);
                end
            end
            ST_CHECK: begin
                if (bus.lock_open_in) begin
                    fail_cnt_d   = {FAIL_W{1'b0}};
                    unlock_cnt_d = {UNL_W{1'b0}};
                    state_d      = ST_UNLOCKED;
                end else begin
                    fail_s = 1'b1;
                end
            end
            ST_UNLOCKED: begin
                if (unlock_cnt_q == UNL_LAST) begin
                    state_d = ST_RELOCK;
                end else begin
                    unlock_cnt_d = unlock_cnt_q + UNL_W'(1);
                end
            end
            ST_RELOCK: begin
                press_cnt_d = {PRS_W{1'b0}};
                timeout_d   = {TO_W{1'b0}};
                state_d     = ST_IDLE;
            end
            ST_LOCKOUT: begin
                if (lockout_cnt_q == LKO_LAST) begin
                    fail_cnt_d = {FAIL_W{1'b0}};
                    state_d    = ST_RELOCK;
                end else begin
                    lockout_cnt_d = lockout_cnt_q + LKO_W'(1);
                end
            end
            default: begin
                state_d = ST_RELOCK;
            end
        endcase

        if (fail_s) begin
            if (fail_cnt_q >= FAIL_LAST) begin
                fail_cnt_d    = FAIL_MAX;
                lockout_cnt_d = {LKO_W{1'b0}};
                state_d       = ST_LOCKOUT;
            end else begin
                fail_cnt_d = fail_cnt_q + FAIL_W'(1);
                state_d    = ST_RELOCK;
            end
        end else begin
            fail_cnt_d = fail_cnt_d;
        end

        lock_reset_d = (state_d == ST_RELOCK) || (state_d == ST_LOCKOUT);
        unlocked_d   = (state_d == ST_UNLOCKED);
        lockout_d    = (state_d == ST_LOCKOUT);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q       <= ST_RELOCK;
            meta_q        <= 2'b00;
            sync_q        <= 2'b00;
            deb_q         <= 2'b00;
            deb_cnt_q     <= {(2*DEB_W){1'b0}};
            press_cnt_q   <= {PRS_W{1'b0}};
            timeout_q     <= {TO_W{1'b0}};
            unlock_cnt_q  <= {UNL_W{1'b0}};
            lockout_cnt_q <= {LKO_W{1'b0}};
            fail_cnt_q    <= {FAIL_W{1'b0}};
            b0_pulse_q    <= 1'b0;
            b1_pulse_q    <= 1'b0;
            lock_reset_q  <= 1'b1;
            unlocked_q    <= 1'b0;
            lockout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            meta_q        <= meta_d;
            sync_q        <= sync_d;
            deb_q         <= deb_d;
            deb_cnt_q     <= deb_cnt_d;
            press_cnt_q   <= press_cnt_d;
            timeout_q     <= timeout_d;
            unlock_cnt_q  <= unlock_cnt_d;
            lockout_cnt_q <= lockout_cnt_d;
            fail_cnt_q    <= fail_cnt_d;
            b0_pulse_q    <= b0_pulse_d;
            b1_pulse_q    <= b1_pulse_d;
            lock_reset_q  <= lock_reset_d;
            unlocked_q    <= unlocked_d;
            lockout_q     <= lockout_d;
        end
    end

    assign bus.b0_pulse_out   = b0_pulse_q;
    assign bus.b1_pulse_out   = b1_pulse_q;
    assign bus.lock_reset_out = lock_reset_q;
    assign bus.unlocked_out   = unlocked_q;
    assign bus.lockout_out    = lockout_q;
    assign bus.fail_count_out = fail_cnt_q;
endmodule
